// File: rtl/ram512_reader.sv
// ram512_reader
//   Streaming read master for ram512. On an accepted start it walks
//   base..base+count-1 (mod 512) and presents each stored word on a
//   valid/ready stream. It flags the final word with out_last and keeps a
//   16-bit running sum of the words the consumer has taken.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start, base, count run request; sampled and latched only in IDLE
//   mem_address        read address to ram512 (always the fetch pointer)
//   mem_in, mem_load   ram512 write side, tied off (read-only master)
//   mem_out            combinational read data for mem_address
//   out_data/valid/ready/last   output stream
//   busy               any state other than IDLE
//   done               one-cycle pulse after the last transfer
//   sum                mod-2^16 sum of words transferred in this/last run
module ram512_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  base,
    input  logic [9:0]  count,
    output logic [8:0]  mem_address,
    output logic [15:0] mem_in,
    output logic        mem_load,
    input  logic [15:0] mem_out,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum
);

    typedef enum logic [1:0] {IDLE, READ, FIN} state_t;

    state_t      state, state_nx;
    logic [8:0]  ptr, ptr_nx;
    logic [9:0]  remaining, remaining_nx;
    logic [15:0] data_nx, sum_nx;
    logic        valid_nx, last_nx;
    logic        fetch, xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            sum       <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            remaining <= remaining_nx;
            out_data  <= data_nx;
            out_valid <= valid_nx;
            out_last  <= last_nx;
            sum       <= sum_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        remaining_nx = remaining;
        data_nx      = out_data;
        valid_nx     = out_valid;
        last_nx      = out_last;
        sum_nx       = sum;
        fetch        = 1'b0;
        xfer         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    ptr_nx       = base;
                    remaining_nx = (count > 10'd512) ? 10'd512 : count;
                    sum_nx       = '0;
                    state_nx     = READ;
                end
            end
            READ: begin
                // The output register is refilled in the same cycle it
                // drains, so an always-ready consumer sees one word/cycle.
                fetch = (remaining != 10'd0) && (!out_valid || out_ready);
                xfer  = out_valid && out_ready;
                if (xfer)
                    sum_nx = sum + out_data;
                if (fetch) begin
                    data_nx      = mem_out;
                    valid_nx     = 1'b1;
                    last_nx      = (remaining == 10'd1);
                    ptr_nx       = ptr + 9'd1;
                    remaining_nx = remaining - 10'd1;
                end else if (xfer) begin
                    valid_nx = 1'b0;
                end
                // Second term only fires for a zero-length run.
                if ((xfer && out_last) || (remaining == 10'd0 && !out_valid))
                    state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_address = ptr;
    assign mem_in      = 16'd0;
    assign mem_load    = 1'b0;
    assign busy        = (state != IDLE);
    assign done        = (state == FIN);

endmodule

// File: tb/tb_ram512_reader.sv
module tb_ram512_reader;

    logic        clk = 1'b0;
    logic        reset, start, out_ready;
    logic [8:0]  base, mem_address;
    logic [9:0]  count;
    logic [15:0] mem_in, mem_out, out_data, sum;
    logic        mem_load, out_valid, out_last, busy, done;

    logic [15:0] mem [512];
    int          checks = 0;
    int          errors = 0;
    int          pat [8] = '{1, 0, 0, 1, 0, 1, 1, 1};

    always #5 clk = ~clk;

    // Behavioural ram512: combinational read, never written by the DUT.
    assign mem_out = mem[mem_address];

    ram512_reader dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
        .mem_address(mem_address), .mem_in(mem_in), .mem_load(mem_load),
        .mem_out(mem_out), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy),
        .done(done), .sum(sum)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc >= 1 && cyc <= 8) ? pat[cyc-1][0] : 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // One run: model = ordered list of words base+n mod 512, n < min(count,512).
    // mode: 0 always ready, 1 fixed pattern, 2 random ready.
    // poke: cycle at which a stray start (base=7) is driven, 0 = none.
    // abort_n: assert reset once this many words were transferred, 0 = none.
    task automatic run(input int b, input int c, input int mode,
                       input int poke, input int abort_n);
        int q[$];
        int n, exp_sum, cyc, xfers, last_x, dones, done_cyc, seen_valid;
        int sd, sa, stalled, w;
        n = (c > 512) ? 512 : c;
        exp_sum = 0;
        for (int j = 0; j < n; j++) q.push_back(int'(mem[(b + j) % 512]));
        cyc = 0; xfers = 0; last_x = -10; dones = 0; done_cyc = -1;
        seen_valid = 0; stalled = 0; sd = 0; sa = 0;

        @(posedge clk); #1;
        start = 1'b1; base = 9'(b); count = 10'(c); out_ready = 1'b1;
        @(posedge clk); #1;                       // edge k accepted start
        start = 1'b0; base = 9'($urandom); count = 10'($urandom);
        out_ready = ready_for(mode, 1);

        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("busy_after_start", int'(busy), 1);
            if (done) begin dones++; done_cyc = cyc; end
            if (stalled) begin
                chk("stall_data", int'(out_data), sd);
                chk("stall_addr", int'(mem_address), sa);
                chk("stall_valid", int'(out_valid), 1);
            end
            // Pointer sits one past every word fetched so far.
            chk("fetch_addr", int'(mem_address), (b + xfers + int'(out_valid)) % 512);
            stalled = 0;
            if (out_valid) begin
                seen_valid = 1;
                if (out_ready) begin
                    if (q.size() == 0) begin
                        chk("extra_word", int'(out_data), -1);
                    end else begin
                        w = q.pop_front();
                        chk("word", int'(out_data), w);
                        chk("last", int'(out_last), int'(q.size() == 0));
                        exp_sum = (exp_sum + w) % 65536;
                    end
                    xfers++;
                    last_x = cyc;
                end else begin
                    stalled = 1; sd = int'(out_data); sa = int'(mem_address);
                end
            end
            if (done) break;
            if (abort_n != 0 && xfers == abort_n) begin
                @(posedge clk); #1; reset = 1'b1;
                @(posedge clk); #1; reset = 1'b0; out_ready = 1'b1;
                @(negedge clk);
                chk("abort_valid", int'(out_valid), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_sum", int'(sum), 0);
                chk("abort_addr", int'(mem_address), 0);
                chk("abort_done", int'(done), 0);
                @(negedge clk);
                chk("abort_no_done", int'(done), 0);
                return;
            end
            if (cyc > 3000) begin
                chk("timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
            out_ready = ready_for(mode, cyc + 1);
            if (poke != 0 && cyc == poke) begin
                start = 1'b1; base = 9'd7; count = 10'd3;
            end else begin
                start = 1'b0;
            end
        end

        chk("done_count", dones, 1);
        chk("done_timing", done_cyc, (n == 0) ? 2 : last_x + 1);
        chk("words_left", q.size(), 0);
        chk("words_taken", xfers, n);
        if (n == 0) chk("zero_no_valid", seen_valid, 0);
        chk("sum_at_done", int'(sum), exp_sum);
        chk("busy_at_done", int'(busy), 1);
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_fin", int'(busy), 0);
        chk("done_pulse_end", int'(done), 0);
        chk("sum_hold", int'(sum), exp_sum);
        chk("mem_load_tied", int'(mem_load), 0);
    endtask

    initial begin
        int b, c, sel;
        reset = 1'b1; start = 1'b0; base = '0; count = '0; out_ready = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 16'(3 * i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_addr", int'(mem_address), 0);
        chk("rst_mem_in", int'(mem_in), 0);
        chk("rst_mem_load", int'(mem_load), 0);
        @(posedge clk); #1; reset = 1'b0;

        run(0, 512, 0, 0, 0);        // full sweep, sum 64768
        run(510, 4, 0, 0, 0);        // wrap 510,511,0,1
        run(100, 6, 1, 0, 0);        // backpressure pattern
        run(0, 0, 0, 0, 0);          // zero count
        run(0, 600, 0, 40, 0);       // clamp + ignored start mid-run
        run(0, 100, 0, 0, 5);        // reset after 5 transfers
        run(20, 2, 0, 0, 0);         // 60, 63

        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
        for (int r = 0; r < 10; r++) begin
            b = $urandom_range(0, 511);
            sel = $urandom_range(0, 5);
            c = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(512, 1023)
                                            : $urandom_range(1, 40);
            run(b, c, 2, (r % 3 == 0) ? 3 : 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
